// File: rtl/enemy_formation.sv
// Invader grid: alive bitmap, formation position and march direction.
// Each frame tick scans every enemy against the projectile box, kills at most one enemy, then advances the march.
module enemy_formation #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int ENEMY_W     = 32,
    parameter int ENEMY_H     = 16,
    parameter int SPACING_X   = 48,
    parameter int SPACING_Y   = 32,
    parameter int PROJ_W      = 4,
    parameter int PROJ_H      = 8,
    parameter int START_X     = 64,
    parameter int START_Y     = 32,
    parameter int STEP_X      = 4,
    parameter int DROP_Y      = 8,
    parameter int RIGHT_LIMIT = 639,
    parameter int BOTTOM_Y    = 448,
    parameter int MOVE_DIV    = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [9:0]           proj_x,
    input  logic [9:0]           proj_y,
    input  logic                 proj_exists,
    output logic                 has_collided,
    output logic [COLS*ROWS-1:0] alive,
    output logic [9:0]           form_x,
    output logic [9:0]           form_y,
    output logic [7:0]           hit_count,
    output logic                 all_dead,
    output logic                 reached_bottom
);

    localparam int N   = COLS * ROWS;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, MOVE} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  col;
    logic [10:0]    col_off;    // col * SPACING_X, accumulated while scanning
    logic [10:0]    row_off;    // row * SPACING_Y, accumulated while scanning
    logic           dir_left;
    logic [MCW-1:0] move_cnt;

    logic        go, hit;
    logic [10:0] ex, ey, px, py;
    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;
    logic [10:0] lc_off, rc_off, br_off;
    logic        right_hit, left_hit, bottom_cond;

    // Current enemy box against the projectile box; all sums kept at 11 bits so nothing wraps
    always_comb begin
        ex  = {1'b0, form_x} + col_off;
        ey  = {1'b0, form_y} + row_off;
        px  = {1'b0, proj_x};
        py  = {1'b0, proj_y};
        go  = tick && !all_dead && !reached_bottom;
        hit = proj_exists && alive[idx] &&
              (px < ex + 11'(ENEMY_W)) && (px + 11'(PROJ_W) > ex) &&
              (py < ey + 11'(ENEMY_H)) && (py + 11'(PROJ_H) > ey);
    end

    // Formation extent from surviving columns/rows only
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_alive[r] = |alive[r*COLS +: COLS];
            for (int c = 0; c < COLS; c++)
                if (alive[r*COLS + c]) col_alive[c] = 1'b1;
        end
        lc_off = '0;
        rc_off = '0;
        br_off = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (col_alive[c]) lc_off = 11'(c * SPACING_X);
        for (int c = 0; c < COLS; c++)
            if (col_alive[c]) rc_off = 11'(c * SPACING_X);
        for (int r = 0; r < ROWS; r++)
            if (row_alive[r]) br_off = 11'(r * SPACING_Y);
        right_hit   = ({1'b0, form_x} + rc_off + 11'(ENEMY_W + STEP_X - 1)) > 11'(RIGHT_LIMIT);
        left_hit    = ({1'b0, form_x} + lc_off) < 11'(STEP_X);
        bottom_cond = ({1'b0, form_y} + br_off + 11'(ENEMY_H)) >= 11'(BOTTOM_Y);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // FSM next state: a missing projectile skips the scan, a hit or last index ends it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = proj_exists ? SCAN : MOVE;
            SCAN:    if (hit || idx == IW'(N - 1)) state_nx = MOVE;
            MOVE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan counters, kill bookkeeping, march step and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx            <= '0;
            col            <= '0;
            col_off        <= '0;
            row_off        <= '0;
            dir_left       <= 1'b0;
            move_cnt       <= '0;
            alive          <= '1;
            form_x         <= 10'(START_X);
            form_y         <= 10'(START_Y);
            hit_count      <= '0;
            has_collided   <= 1'b0;
            all_dead       <= 1'b0;
            reached_bottom <= 1'b0;
        end else begin
            has_collided <= 1'b0;
            if (alive != '0 && bottom_cond) reached_bottom <= 1'b1;
            case (state)
                IDLE: if (go) begin
                    idx     <= '0;
                    col     <= '0;
                    col_off <= '0;
                    row_off <= '0;
                end
                SCAN: if (hit) begin
                    alive[idx]   <= 1'b0;
                    has_collided <= 1'b1;
                    all_dead     <= (alive & ~(N'(1) << idx)) == '0;
                    if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                end else begin
                    idx <= idx + 1'b1;
                    if (col == CW'(COLS - 1)) begin
                        col     <= '0;
                        col_off <= '0;
                        row_off <= row_off + 11'(SPACING_Y);
                    end else begin
                        col     <= col + 1'b1;
                        col_off <= col_off + 11'(SPACING_X);
                    end
                end
                MOVE: if (move_cnt < MCW'(MOVE_DIV - 1)) begin
                    move_cnt <= move_cnt + 1'b1;
                end else begin
                    move_cnt <= '0;
                    if (!all_dead) begin
                        if (!dir_left) begin
                            if (right_hit) begin
                                form_y   <= form_y + 10'(DROP_Y);
                                dir_left <= 1'b1;
                            end else form_x <= form_x + 10'(STEP_X);
                        end else begin
                            if (left_hit) begin
                                form_y   <= form_y + 10'(DROP_Y);
                                dir_left <= 1'b0;
                            end else form_x <= form_x - 10'(STEP_X);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_formation.sv
// Directed bench for enemy_formation: reset, hits/misses, march reversal, alive-aware edge, win and invasion.
module tb_enemy_formation;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [9:0]  proj_x = '0, proj_y = '0;
    logic        proj_exists = 1'b0;
    logic        has_collided;
    logic [31:0] alive;
    logic [9:0]  form_x, form_y;
    logic [7:0]  hit_count;
    logic        all_dead, reached_bottom;

    logic        tick2 = 1'b0;
    logic [9:0]  zero10 = '0;
    logic        zero1 = 1'b0;
    logic        has_collided2;
    logic [31:0] alive2;
    logic [9:0]  form_x2, form_y2;
    logic [7:0]  hit_count2;
    logic        all_dead2, reached_bottom2;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    enemy_formation #(.MOVE_DIV(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .proj_x(proj_x), .proj_y(proj_y),
        .proj_exists(proj_exists), .has_collided(has_collided), .alive(alive),
        .form_x(form_x), .form_y(form_y), .hit_count(hit_count),
        .all_dead(all_dead), .reached_bottom(reached_bottom)
    );

    // Narrow field and shallow invasion line so the bottom is reached after one drop
    enemy_formation #(.MOVE_DIV(1), .RIGHT_LIMIT(439), .BOTTOM_Y(152)) dut2 (
        .clk(clk), .rst(rst), .tick(tick2), .proj_x(zero10), .proj_y(zero10),
        .proj_exists(zero1), .has_collided(has_collided2), .alive(alive2),
        .form_x(form_x2), .form_y(form_y2), .hit_count(hit_count2),
        .all_dead(all_dead2), .reached_bottom(reached_bottom2)
    );

    always @(negedge clk) if (has_collided === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame(input logic [9:0] px, input logic [9:0] py, input logic pe);
        proj_x = px; proj_y = py; proj_exists = pe;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic frame2();
        @(negedge clk) tick2 = 1'b1;
        @(negedge clk) tick2 = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int p0;
        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_form_x", form_x, 64);
        chk("rst_form_y", form_y, 32);
        chk("rst_alive", alive, 32'hFFFFFFFF);
        chk("rst_hits", hit_count, 0);
        chk("rst_flags", {has_collided, all_dead, reached_bottom}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- march with all columns alive: right edge passes up to 268, then 272 reverses
        for (int i = 0; i < 51; i++) frame(10'd0, 10'd0, 1'b0);
        chk("march51_x", form_x, 268);
        chk("march51_y", form_y, 32);
        frame(10'd0, 10'd0, 1'b0);
        chk("march52_x", form_x, 272);
        frame(10'd0, 10'd0, 1'b0);
        chk("rev_x", form_x, 272);
        chk("rev_y", form_y, 40);
        frame(10'd0, 10'd0, 1'b0);
        chk("left_x", form_x, 268);

        // ---- reset mid-scan while aiming at the last enemy (ex=604, ey=136)
        proj_x = 10'd606; proj_y = 10'd138; proj_exists = 1'b1;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_form_x", form_x, 64);
        chk("mid_form_y", form_y, 32);
        chk("mid_alive", alive, 32'hFFFFFFFF);
        chk("mid_hits", hit_count, 0);
        @(negedge clk) rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_no_pulse", pulses, 0);
        chk("mid_alive_after", alive, 32'hFFFFFFFF);

        // ---- hit on enemy 0 with exact pulse timing
        proj_x = 10'd70; proj_y = 10'd40; proj_exists = 1'b1;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        chk("hit0_pulse_on", has_collided, 1);
        @(negedge clk);
        chk("hit0_pulse_off", has_collided, 0);
        repeat (40) @(negedge clk);
        chk("hit0_alive", alive, 32'hFFFFFFFE);
        chk("hit0_hits", hit_count, 1);
        chk("hit0_x", form_x, 68);
        chk("hit0_pulses", pulses, 1);

        // ---- dead enemy not re-hit, no shot, clear miss
        frame(10'd70, 10'd40, 1'b1);
        chk("rehit_pulses", pulses, 1);
        frame(10'd70, 10'd40, 1'b0);
        chk("noshot_pulses", pulses, 1);
        frame(10'd600, 10'd400, 1'b1);
        chk("miss_pulses", pulses, 1);
        chk("miss_alive", alive, 32'hFFFFFFFE);
        chk("miss_x", form_x, 80);

        // ---- kill column 7 (formation at 80, 84, 88, 92 during the scans)
        frame(10'd418, 10'd34, 1'b1);
        frame(10'd422, 10'd66, 1'b1);
        frame(10'd426, 10'd98, 1'b1);
        frame(10'd430, 10'd130, 1'b1);
        chk("col7_alive", alive, 32'h7F7F7F7E);
        chk("col7_hits", hit_count, 5);
        chk("col7_x", form_x, 96);

        // ---- right edge now set by column 6: 316 passes, 320 reverses
        for (int i = 0; i < 55; i++) frame(10'd0, 10'd0, 1'b0);
        chk("edge6_316", form_x, 316);
        frame(10'd0, 10'd0, 1'b0);
        chk("edge6_320", form_x, 320);
        chk("edge6_y32", form_y, 32);
        frame(10'd0, 10'd0, 1'b0);
        chk("edge6_rev_x", form_x, 320);
        chk("edge6_rev_y", form_y, 40);
        frame(10'd0, 10'd0, 1'b0);
        chk("edge6_left", form_x, 316);

        // ---- kill all 32 in index order; formation steps +4 per frame until the last kill
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        p0 = pulses;
        for (int k = 0; k < 32; k++)
            frame(10'(64 + 4*k + (k % 8)*48 + 2), 10'(32 + (k / 8)*32 + 2), 1'b1);
        chk("win_pulses", pulses - p0, 32);
        chk("win_alive", alive, 0);
        chk("win_all_dead", all_dead, 1);
        chk("win_hits", hit_count, 32);
        chk("win_x", form_x, 188);
        frame(10'd0, 10'd0, 1'b0);
        chk("win_frozen_x", form_x, 188);
        chk("win_frozen_y", form_y, 32);

        // ---- invasion on the narrow-field instance: 64 -> 68 -> 72, then drop to 40
        frame2();
        frame2();
        chk("bot_x72", form_x2, 72);
        chk("bot_not_yet", reached_bottom2, 0);
        frame2();
        chk("bot_drop_y", form_y2, 40);
        chk("bot_set", reached_bottom2, 1);
        frame2();
        chk("bot_frozen_x", form_x2, 72);
        chk("bot_frozen_y", form_y2, 40);
        chk("bot_sticky", reached_bottom2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
